imem_loader: RTL

Program loader for the byte-addressable instruction memory: the write-side counterpart of the instruction fetch path. Accepts a byte stream over a valid/ready handshake, assembles each 32-bit instruction word, and commits it into instruction memory as four big-endian byte writes. The fetch path reads word `k` from byte addresses `base+4k`..`base+4k+3`, MSB first. Holds the CPU (`CPU_HOLD`) while a load is in progress.

---
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes into 32-bit words and writes each word to
// instruction memory as four big-endian byte writes. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
`default_nettype none

module imem_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [LEN_W-1:0]  LEN_WORDS,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_DATA,
    output logic              MEM_WE,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [LEN_W-1:0]  WORD_COUNT
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_FIN   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_FIN   = 3'd4
    } state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] word_ptr;   // byte address of the word being assembled/written
    logic [LEN_W-1:0]  len_q;
    logic [31:0]       word_buf;
    logic [1:0]        byte_idx;
    logic [1:0]        wr_idx;

    logic [31:0]       buf_next;
    logic              last_word;

    assign buf_next  = {word_buf[23:0], BYTE_IN};
    assign last_word = (WORD_COUNT + LEN_W'(1)) == len_q;

    // Byte i of a word in memory order (i=0 is the MSB).
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;
    logic       err_q;
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            word_ptr   <= '0;
            len_q      <= '0;
            word_buf   <= '0;
            byte_idx   <= '0;
            wr_idx     <= '0;
            BYTE_READY <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_DATA   <= '0;
            MEM_WE     <= 1'b0;
            CPU_HOLD   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            WORD_COUNT <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        word_ptr   <= BASE_ADDR & ~ADDR_W'(3);
                        len_q      <= LEN_WORDS;
                        WORD_COUNT <= '0;
                        byte_idx   <= '0;
                        wr_idx     <= '0;
                        BUSY       <= 1'b1;
                        CPU_HOLD   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_q      <= '0;
                        err_q      <= 1'b0;
`endif
                        if (LEN_WORDS == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state      <= S_CHECK;
                            BYTE_READY <= 1'b1;
`else
                            state      <= S_FIN;
                            DONE       <= 1'b1;
`endif
                        end else begin
                            state      <= S_RECV;
                            BYTE_READY <= 1'b1;
                        end
                    end
                end

                S_RECV: begin
                    if (BYTE_VALID && BYTE_READY) begin
                        word_buf <= buf_next;
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_q    <= chk_q ^ BYTE_IN;
`endif
                        // Fourth byte: first memory write is presented on the next cycle.
                        if (byte_idx == 2'd3) begin
                            state      <= S_WRITE;
                            BYTE_READY <= 1'b0;
                            MEM_WE     <= 1'b1;
                            MEM_ADDR   <= word_ptr;
                            MEM_DATA   <= buf_next[31:24];
                            wr_idx     <= 2'd0;
                        end
                    end
                end

                S_WRITE: begin
                    if (wr_idx != 2'd3) begin
                        wr_idx   <= wr_idx + 2'd1;
                        MEM_ADDR <= MEM_ADDR + ADDR_W'(1);
                        MEM_DATA <= pick(word_buf, wr_idx + 2'd1);
                    end else begin
                        MEM_WE     <= 1'b0;
                        WORD_COUNT <= WORD_COUNT + LEN_W'(1);
                        word_ptr   <= word_ptr + ADDR_W'(4);
                        if (!last_word) begin
                            state      <= S_RECV;
                            BYTE_READY <= 1'b1;
                        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state      <= S_CHECK;
                            BYTE_READY <= 1'b1;
`else
                            state      <= S_FIN;
                            DONE       <= 1'b1;
`endif
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (BYTE_VALID && BYTE_READY) begin
                        err_q      <= (BYTE_IN != chk_q);
                        BYTE_READY <= 1'b0;
                        DONE       <= 1'b1;
                        state      <= S_FIN;
                    end
                end
`endif

                S_FIN: begin
                    DONE     <= 1'b0;
                    BUSY     <= 1'b0;
                    CPU_HOLD <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state      <= S_IDLE;
                    BYTE_READY <= 1'b0;
                    MEM_WE     <= 1'b0;
                    DONE       <= 1'b0;
                    BUSY       <= 1'b0;
                    CPU_HOLD   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
